gray_seq_ctrl: RTL and testbench

GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

---
 rtl/gray_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_gray_seq_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: stepped binary/Gray code sequencer.
// A sequence is armed from IDLE by a start pulse, which latches the direction,
// the run mode and the last value to emit. Each accepted step in RUN emits the
// current count as a registered binary/Gray pair with a one-cycle valid pulse.
// A one-shot sequence ends through DONE, which produces a single done pulse.
// A continuous sequence wraps back to its start value until stop is seen.
module gray_seq_ctrl #(
   parameter int width = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode_down,
   input  logic             cont,
   input  logic [width-1:0] limit,
   input  logic             step_en,
   input  logic             stop,
   output logic             busy,
   output logic [width-1:0] b_out,
   output logic [width-1:0] g_out,
   output logic             valid,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_next_state;
   logic             w_step;      // a code is emitted at this edge
   logic             w_at_limit;  // current count is the last value of the lap
   logic             w_arm;       // start accepted at this edge

   logic [width-1:0] r_cnt;
   logic             r_down;
   logic             r_cont;
   logic [width-1:0] r_limit;

   assign w_at_limit = (r_cnt == r_limit);
   assign w_arm      = (r_state == S_IDLE) && start;

   // Next-state decode; stop takes priority over a simultaneous step request.
   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_step       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_next_state = S_RUN;
         end
         S_RUN: begin
            if (stop) begin
               w_next_state = S_IDLE;
            end else if (step_en) begin
               w_step = 1'b1;
               if (w_at_limit && !r_cont) w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // State register with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Counter, latched configuration and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_down  <= 1'b0;
         r_cont  <= 1'b0;
         r_limit <= '0;
         b_out   <= '0;
         g_out   <= '0;
         valid   <= 1'b0;
         done    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         valid <= w_step;
         // done lands one cycle after the final valid, on the DONE -> IDLE edge.
         done  <= (r_state == S_DONE);
         busy  <= (w_next_state == S_RUN);

         if (w_arm) begin
            r_down  <= mode_down;
            r_cont  <= cont;
            r_limit <= limit;
            r_cnt   <= mode_down ? '1 : '0;
         end

         if (w_step) begin
            b_out <= r_cnt;
            g_out <= r_cnt ^ (r_cnt >> 1);
            if (w_at_limit) begin
               // End of a lap: rewind to the start value (only matters when continuous).
               r_cnt <= r_down ? '1 : '0;
            end else if (r_down) begin
               r_cnt <= r_cnt - ONE;
            end else begin
               r_cnt <= r_cnt + ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: directed test of gray_seq_ctrl (width = 4).
// A behavioural model describes each sequence as a lap of known length whose
// k-th code is k (up) or 2^width-1-k (down); it is compared with the DUT on
// every clock. Directed tests also pin emitted sequences to literal tables.
module tb_gray_seq_ctrl;

   localparam int W    = 4;
   localparam int MAXV = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         mode_down;
   logic         cont;
   logic [W-1:0] limit;
   logic         step_en;
   logic         stop;
   logic         busy;
   logic [W-1:0] b_out;
   logic [W-1:0] g_out;
   logic         valid;
   logic         done;

   gray_seq_ctrl #(.width(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mode_down (mode_down),
      .cont      (cont),
      .limit     (limit),
      .step_en   (step_en),
      .stop      (stop),
      .busy      (busy),
      .b_out     (b_out),
      .g_out     (g_out),
      .valid     (valid),
      .done      (done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic check_seq(input string name, input int exp[$], input int act[$]);
      check({name, " length"}, act.size(), exp.size());
      for (int i = 0; i < exp.size() && i < act.size(); i++)
         check($sformatf("%s[%0d]", name, i), act[i], exp[i]);
   endtask

   // ---------------- behavioural model ----------------
   bit m_run, m_fin, m_down, m_cont;
   int m_len, m_k, m_v;
   int e_b, e_g;
   bit e_valid, e_done, e_busy;

   function automatic int gray(input int v);
      return v ^ (v >> 1);
   endfunction

   // ---------------- capture of emitted codes ----------------
   int q_b[$];
   int q_g[$];
   int q_vc[$];
   int n_done;
   int cyc_n = 0;
   int last_valid_cyc = 0;
   int done_cyc = 0;

   // Advance the model on each edge, then compare and capture once the DUT has settled.
   always @(posedge clk) begin
      if (rst) begin
         m_run = 0; m_fin = 0; m_down = 0; m_cont = 0; m_len = 1; m_k = 0;
         e_b = 0; e_g = 0; e_valid = 0; e_done = 0;
      end else begin
         e_valid = 0;
         e_done  = 0;
         if (m_fin) begin
            e_done = 1;
            m_fin  = 0;
         end else if (m_run) begin
            if (stop) begin
               m_run = 0;
            end else if (step_en) begin
               m_v     = m_down ? MAXV - m_k : m_k;
               e_b     = m_v;
               e_g     = gray(m_v);
               e_valid = 1;
               m_k++;
               if (m_k == m_len) begin
                  if (m_cont) m_k = 0;
                  else begin
                     m_run = 0;
                     m_fin = 1;
                  end
               end
            end
         end else if (start) begin
            m_down = mode_down;
            m_cont = cont;
            m_len  = mode_down ? MAXV - int'(limit) + 1 : int'(limit) + 1;
            m_k    = 0;
            m_run  = 1;
         end
      end
      e_busy = m_run;
      #1;
      check("model b_out", b_out, e_b);
      check("model g_out", g_out, e_g);
      check("model valid", valid, e_valid);
      check("model done",  done,  e_done);
      check("model busy",  busy,  e_busy);
      if (valid === 1'b1) begin
         q_b.push_back(int'(b_out));
         q_g.push_back(int'(g_out));
         q_vc.push_back(cyc_n);
         last_valid_cyc = cyc_n;
      end
      if (done === 1'b1) begin
         n_done++;
         done_cyc = cyc_n;
      end
      cyc_n++;
   end

   // ---------------- stimulus helpers (inputs change on the falling edge) ----------------
   task automatic clear_cap();
      q_b.delete();
      q_g.delete();
      q_vc.delete();
      n_done = 0;
   endtask

   task automatic idle(input int n);
      start = 0; step_en = 0; stop = 0;
      repeat (n) @(negedge clk);
   endtask

   task automatic begin_seq(input logic d, input logic c, input logic [W-1:0] l);
      start = 1; mode_down = d; cont = c; limit = l;
      @(negedge clk);
      start = 0;
   endtask

   task automatic steps(input int n);
      step_en = 1;
      repeat (n) @(negedge clk);
      step_en = 0;
   endtask

   task automatic stop_cycle();
      stop = 1; step_en = 1;
      @(negedge clk);
      stop = 0; step_en = 0;
   endtask

   int exp_b[$];
   int exp_g[$];

   initial begin
      rst = 1; start = 1; mode_down = 0; cont = 0; limit = '0; step_en = 0; stop = 0;

      // Reset held two cycles with start asserted.
      repeat (2) @(negedge clk);
      rst = 0; start = 0;
      @(negedge clk);
      check("reset busy",  busy,  0);
      check("reset valid", valid, 0);
      check("reset done",  done,  0);
      check("reset b_out", b_out, 0);
      check("reset g_out", g_out, 0);

      // Up, one-shot, full range.
      clear_cap();
      begin_seq(0, 0, 4'd15);
      steps(16);
      idle(3);
      exp_g = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
      check_seq("up gray", exp_g, q_g);
      check("up done count", n_done, 1);
      check("up done lag", done_cyc - last_valid_cyc, 1);
      check("up busy after", busy, 0);

      // Down, one-shot, limit 12.
      clear_cap();
      begin_seq(1, 0, 4'd12);
      steps(4);
      idle(3);
      exp_b = '{15, 14, 13, 12};
      exp_g = '{8, 9, 11, 10};
      check_seq("down bin", exp_b, q_b);
      check_seq("down gray", exp_g, q_g);
      check("down done count", n_done, 1);
      check("down done lag", done_cyc - last_valid_cyc, 1);

      // Continuous, limit 3, then stop.
      clear_cap();
      begin_seq(0, 1, 4'd3);
      steps(10);
      exp_g = '{0, 1, 3, 2, 0, 1, 3, 2, 0, 1};
      check_seq("cont gray", exp_g, q_g);
      check("cont no done", n_done, 0);
      check("cont busy", busy, 1);
      clear_cap();
      stop_cycle();
      check("stop busy", busy, 0);
      steps(3);
      idle(2);
      check("stop no valid", q_b.size(), 0);
      check("stop no done", n_done, 0);

      // Gapped steps 1,0,0,1 in down mode.
      clear_cap();
      begin_seq(1, 0, 4'd0);
      step_en = 1; @(negedge clk);
      step_en = 0; @(negedge clk);
      check("gap1 valid", valid, 0);
      check("gap1 held", g_out, 8);
      @(negedge clk);
      check("gap2 held", g_out, 8);
      step_en = 1; @(negedge clk);
      step_en = 0;
      exp_g = '{8, 9};
      check_seq("gap gray", exp_g, q_g);
      if (q_vc.size() == 2) check("gap spacing", q_vc[1] - q_vc[0], 3);
      stop_cycle();
      idle(2);

      // Stop wins over a simultaneous step.
      clear_cap();
      begin_seq(0, 0, 4'd15);
      stop_cycle();
      idle(1);
      check("stop+step no valid", q_b.size(), 0);

      // Start during RUN does not reload.
      clear_cap();
      begin_seq(0, 0, 4'd15);
      steps(2);
      start = 1; mode_down = 1; limit = 4'd5; step_en = 1;
      @(negedge clk);
      start = 0;
      steps(2);
      stop_cycle();
      idle(2);
      exp_b = '{0, 1, 2, 3, 4};
      check_seq("start in run", exp_b, q_b);

      // Reset in the middle of a run.
      begin_seq(0, 1, 4'd15);
      steps(3);
      check("pre-rst b_out", b_out, 2);
      rst = 1; step_en = 1;
      @(negedge clk);
      check("rst b_out", b_out, 0);
      check("rst g_out", g_out, 0);
      check("rst valid", valid, 0);
      check("rst busy",  busy,  0);
      rst = 0; step_en = 1;
      @(negedge clk);
      step_en = 0;
      check("post-rst busy",  busy,  0);
      check("post-rst valid", valid, 0);

      // Limit equal to the start value: exactly one code, then done.
      clear_cap();
      begin_seq(0, 0, 4'd0);
      steps(3);
      idle(2);
      exp_b = '{0};
      check_seq("lim0 up", exp_b, q_b);
      check("lim0 up done", n_done, 1);
      clear_cap();
      begin_seq(1, 0, 4'd15);
      steps(3);
      idle(2);
      exp_b = '{15};
      exp_g = '{8};
      check_seq("lim15 down bin", exp_b, q_b);
      check_seq("lim15 down gray", exp_g, q_g);
      check("lim15 down done", n_done, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
